// File: rtl/pattern_count_engine.sv
// Serial pattern detector that captures a DATA_W-bit count and then holds out_valid for that many cycles.
// Optional detection timeout is compiled in with `define PCE_TIMEOUT_EN.
module pattern_count_engine #(
  parameter int               PAT_W       = 4,
  parameter logic [PAT_W-1:0] PATTERN     = 4'b1101,
  parameter int               DATA_W      = 8,
  parameter int               TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sin,
  input  logic              repeat_en,
  output logic              ready,
  output logic              busy,
  output logic              match,
  output logic              capture_en,
  output logic              out_valid,
  output logic [DATA_W-1:0] remaining,
  output logic              done,
  output logic              timeout_err
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_DETECT,
    S_CAPTURE,
    S_COUNT,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [PAT_W-2:0]  sr_reg;
  logic [PAT_W-1:0]  window;
  logic [FILL_W-1:0] fill_reg;
  logic [BIT_W-1:0]  bit_reg;
  logic [DATA_W-1:0] dcnt_reg;
  logic [DATA_W-1:0] cnt_shift;
  logic              fill_ok;
  logic              match_raw;
  logic              last_bit;
  logic              cap_nonzero;
  logic              timeout_hit;

  assign window      = {sr_reg, sin};
  // The fill check keeps the cleared shift register from faking a hit on early bits.
  assign fill_ok     = (fill_reg >= FILL_W'(PAT_W - 1));
  assign match_raw   = (window == PATTERN) && fill_ok;
  assign last_bit    = (bit_reg == BIT_W'(DATA_W - 1));
  assign cap_nonzero = (cnt_shift != '0);

  generate
    if (DATA_W > 1) begin : g_cap
      logic [DATA_W-2:0] cap_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cap_reg <= '0;
        end else if (state_reg == S_ARM) begin
          cap_reg <= '0;
        end else if (state_reg == S_CAPTURE) begin
          cap_reg <= cnt_shift[DATA_W-2:0];
        end
      end

      assign cnt_shift = {cap_reg, sin};
    end else begin : g_cap1
      assign cnt_shift = sin;
    end
  endgenerate

`ifdef PCE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] tcnt_reg;
  logic            terr_reg;

  // A match on the final allowed cycle takes priority over the timeout.
  assign timeout_hit = (state_reg == S_DETECT) &&
                       (tcnt_reg == TO_W'(TIMEOUT_CYC - 1)) && !match_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_reg <= '0;
      terr_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_ARM: begin
          tcnt_reg <= '0;
          terr_reg <= 1'b0;
        end
        S_DETECT: begin
          tcnt_reg <= tcnt_reg + 1'b1;
          if (timeout_hit) begin
            terr_reg <= 1'b1;
          end
        end
        S_DONE: tcnt_reg <= '0;
        default: ;
      endcase
    end
  end

  assign timeout_err = terr_reg;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    busy       = (state_reg != S_IDLE);
    match      = 1'b0;
    capture_en = 1'b0;
    out_valid  = 1'b0;
    remaining  = '0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_next = S_ARM;
        end
      end
      S_ARM: begin
        if (!start) begin
          state_next = S_DETECT;
        end
      end
      S_DETECT: begin
        match = match_raw;
        if (match_raw) begin
          state_next = S_CAPTURE;
        end else if (timeout_hit) begin
          state_next = S_IDLE;
        end
      end
      S_CAPTURE: begin
        capture_en = 1'b1;
        if (last_bit) begin
          state_next = cap_nonzero ? S_COUNT : S_DONE;
        end
      end
      S_COUNT: begin
        out_valid = 1'b1;
        remaining = dcnt_reg;
        if (dcnt_reg <= DATA_W'(1)) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = repeat_en ? S_DETECT : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_reg   <= '0;
      fill_reg <= '0;
      bit_reg  <= '0;
      dcnt_reg <= '0;
    end else begin
      case (state_reg)
        S_ARM: begin
          sr_reg   <= '0;
          fill_reg <= '0;
          bit_reg  <= '0;
        end
        S_DETECT: begin
          sr_reg  <= window[PAT_W-2:0];
          bit_reg <= '0;
          if (fill_reg != FILL_W'(PAT_W)) begin
            fill_reg <= fill_reg + 1'b1;
          end
        end
        S_CAPTURE: begin
          bit_reg <= bit_reg + 1'b1;
          if (last_bit && cap_nonzero) begin
            dcnt_reg <= cnt_shift;
          end
        end
        S_COUNT: begin
          if (dcnt_reg != '0) begin
            dcnt_reg <= dcnt_reg - 1'b1;
          end
        end
        S_DONE: begin
          // Re-arming straight into DETECT must start from a clean window.
          sr_reg   <= '0;
          fill_reg <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pattern_count_engine.md
# pattern_count_engine

Parametrised serial pattern-detect / capture / countdown engine for the counter-and-detector subsystem. It contains its own controller and datapath. After a start handshake it watches a serial bit stream for a programmable pattern, captures the next DATA_W bits as an unsigned count N, and asserts `out_valid` for exactly N cycles. It adds an optional re-arm mode and a compile-time detection timeout.

## Interface
Parameters:
- PAT_W, 4, pattern length in bits (≥2)
- PATTERN, 4'b1101, pattern to match, MSB received first
- DATA_W, 8, captured count width (≥1)
- TIMEOUT_CYC, 256, detection timeout in cycles (used only with macro)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  start request, level
- sin  in  1  serial data, sampled every rising edge
- repeat_en  in  1  re-arm to DETECT after DONE instead of IDLE
- ready  out  1  high in IDLE
- busy  out  1  high in any state except IDLE
- match  out  1  pattern hit this cycle (Mealy, DETECT only)
- capture_en  out  1  high in CAPTURE
- out_valid  out  1  high in COUNT
- remaining  out  DATA_W  downcounter value; 0 outside COUNT
- done  out  1  one-cycle pulse in DONE
- timeout_err  out  1  sticky timeout flag

## Operation
- States: IDLE, ARM, DETECT, CAPTURE, COUNT, DONE.
- IDLE: ready=1. start=1 → ARM.
- ARM: clears the shift register, fill counter, bit counter and `timeout_err`. It stays in ARM while start=1; start=0 → DETECT.
- DETECT:
  - Each cycle: sr <= {sr[PAT_W-2:0], sin}; the fill counter saturates at PAT_W.
  - Window = {sr[PAT_W-2:0], sin}.
  - match=1 when window==PATTERN and fill ≥ PAT_W-1, i.e. the current bit is at least the PAT_W-th received. This blocks false hits from the cleared register.
  - Detection is overlapping.
  - match → CAPTURE.
- CAPTURE:
  - DATA_W cycles, MSB first: cnt <= {cnt[DATA_W-2:0], sin}.
  - On the DATA_W-th bit the full value V = {cnt[DATA_W-2:0], sin} is formed.
  - V≠0: load downcounter with V → COUNT.
  - V=0 → DONE.
- COUNT:
  - out_valid=1; remaining = downcounter.
  - The downcounter decrements each cycle.
  - At value 1 → DONE, so out_valid is high exactly V cycles.
- DONE:
  - done=1 for one cycle.
  - repeat_en=1 → DETECT, with sr, fill and the timeout counter cleared.
  - repeat_en=0 → IDLE.
  - repeat_en is sampled in DONE only.
- start is ignored outside IDLE and ARM. sin is ignored in IDLE, ARM, COUNT and DONE.
- Arithmetic is unsigned; the downcounter never wraps. Maximum burst length is 2^DATA_W−1.

## Timing
- Reset: state IDLE; ready=1. busy, match, capture_en, out_valid, done and timeout_err are 0; remaining=0. All registers are cleared.
- rst mid-operation forces IDLE outputs immediately (asynchronously), with no done pulse.
- All outputs except match are decoded from registered state. match is combinational from state, sr and sin.
- Latency from the match cycle:
  - CAPTURE covers the next DATA_W cycles.
  - The first out_valid is in the cycle after the last capture bit.
  - done follows the last out_valid cycle.
  - For V=0, done is in the cycle after the last capture bit.
- Minimum start pulse is one cycle: IDLE → ARM → DETECT, with the first sin sampled in the first DETECT cycle.

## Configuration
- Macro PCE_TIMEOUT_EN, defined:
  - A counter runs in DETECT.
  - If TIMEOUT_CYC DETECT cycles pass with no match, the next state is IDLE and timeout_err is set.
  - timeout_err holds until ARM, or until rst.
  - A match on cycle TIMEOUT_CYC itself wins over the timeout.
- Macro undefined: there is no timeout logic. DETECT waits indefinitely, and timeout_err is tied to 0.

## Test plan
(Default parameters unless stated.)
- Start pulse, then sin = 1,1,0,1 followed by 0000_0011 → match on the 4th bit. capture_en for 8 cycles, then out_valid for 3 cycles with remaining 3,2,1. done pulses, ready returns to 1.
- sin = 1,1,1,0,1 after start → a single match on the 5th bit (overlap handled); no match on earlier bits.
- Pattern followed by 0x00 → out_valid never asserts; done in the cycle after the 8th capture bit.
- repeat_en=1, two back-to-back frames with counts 0x02 and 0x01 → out_valid for 2 cycles, then done, then DETECT without ready. Second frame gives out_valid for 1 cycle; two done pulses in total.
- rst asserted during COUNT with remaining=5 → out_valid=0, remaining=0, ready=1 immediately; no done pulse.
- PCE_TIMEOUT_EN with TIMEOUT_CYC=16 and sin held 0 → IDLE after 16 DETECT cycles with timeout_err=1. A new start clears it in ARM.
